uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single uart_top transmit path (tx_data/tx_start/tx_busy)

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-based round-robin arbiter sharing one UART transmit path
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TO   = 255,
    parameter int START_TO  = 15
) (
    input  logic                        MAX10_CLK1_50,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic                        start_to_err
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int IW   = $clog2(IDLE_TO + 1);
    localparam int SW   = $clog2(START_TO + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [SW-1:0]     start_q, start_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] txd_q, txd_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx, cand;
    logic [DATA_W-1:0] pick_data, owner_data;
    logic [BW-1:0]     burst_inc;

    // Search starts just after the last owner so the releasing requester ranks lowest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_data  = req_data[int'(pick_idx) * DATA_W +: DATA_W];
    assign owner_data = req_data[int'(grant_q) * DATA_W +: DATA_W];
    assign burst_inc  = burst_q + BW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        start_d = start_q;
        last_d  = last_q;
        err_d   = err_q;
        txd_d   = txd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_LOAD;
                    grant_d = pick_idx;
                    txd_d   = pick_data;
                end
            end
            S_LOAD: begin
                burst_d = burst_inc;
                last_d  = req_last[grant_q] | (burst_inc == BW'(MAX_BURST));
                start_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (start_q == SW'(START_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_DONE;
                end else begin
                    start_d = start_q + SW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        ptr_d   = grant_q;
                        burst_d = '0;
                        idle_d  = '0;
                    end else if (req_valid[grant_q]) begin
                        state_d = S_LOAD;
                        txd_d   = owner_data;
                    end else begin
                        state_d = S_HOLD;
                        idle_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (req_valid[grant_q]) begin
                    state_d = S_LOAD;
                    idle_d  = '0;
                    txd_d   = owner_data;
                end else if (idle_q == IW'(IDLE_TO - 1)) begin
                    state_d = S_IDLE;
                    ptr_d   = grant_q;
                    burst_d = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            burst_q <= '0;
            idle_q  <= '0;
            start_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            start_q <= start_d;
            last_q  <= last_d;
            err_q   <= err_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_LOAD) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign tx_start     = (state_q == S_LOAD);
    assign tx_data      = txd_q;
    assign grant_id     = grant_q;
    assign arb_busy     = (state_q != S_IDLE);
    assign start_to_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with queue-based reference model
module tb_uart_tx_arbiter;
    localparam int N         = 4;
    localparam int MAX_BURST = 16;
    localparam int IDLE_TO   = 255;
    localparam int START_TO  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        start_to_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = N - 1;
    logic [8:0] rq [N][$];
    logic [9:0] exp_q [$];
    int start_cyc_q [$];
    logic [3:0] acc = '0;
    bit stuck = 1'b0;
    bit hold_en = 1'b1;

    uart_tx_arbiter dut (
        .MAX10_CLK1_50(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .start_to_err(start_to_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int id, input logic [7:0] d, input bit last);
        rq[id].push_back({last, d});
    endtask

    task automatic push_msg(input int id, input int len, input bit with_last);
        for (int n = 0; n < len; n++) push_byte(id, 8'($urandom), with_last && (n == len - 1));
    endtask

    // Reference: whole-message round robin with burst cap, from the queued bytes.
    task automatic predict();
        logic [8:0] m [N][$];
        logic [8:0] b;
        int g, cnt;
        bit found;
        for (int i = 0; i < N; i++) m[i] = rq[i];
        while (1) begin
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m[(model_ptr + k) % N].size() > 0) begin
                    found = 1'b1;
                    g = (model_ptr + k) % N;
                end
            end
            if (!found) break;
            cnt = 0;
            do begin
                b = m[g].pop_front();
                exp_q.push_back({2'(g), b[7:0]});
                cnt++;
            end while (!b[8] && cnt < MAX_BURST && m[g].size() > 0);
            model_ptr = g;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !arb_busy && !tx_busy && all_empty()) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail(name);
        else checks++;
    endtask

    task automatic wait_starts(input string name, input int target);
        int n = 0;
        while (start_cyc_q.size() < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail(name);
    endtask

    // Requester drivers: pop an accepted byte, present the next one.
    initial begin
        logic [8:0] t;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) t = rq[i].pop_front();
                if (rq[i].size() > 0) begin
                    t = rq[i][0];
                    req_valid[i] = 1'b1;
                    req_data[i*8 +: 8] = t[7:0];
                    req_last[i] = t[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // UART model: busy follows tx_start unless stuck.
    initial begin
        logic [7:0] d;
        int lat;
        forever begin
            @(negedge clk);
            if (tx_start && !stuck) begin
                d = tx_data;
                lat = $urandom_range(1, 6);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (lat) begin
                    @(negedge clk);
                    if (hold_en) chk("tx_data_hold", tx_data, d);
                    @(posedge clk);
                end
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each transmit start.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            if (tx_start) begin
                start_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=%0d/%0h required=none", grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", grant_id, e[9:8]);
                    chk("tx_data", tx_data, e[7:0]);
                    chk("req_ready", req_ready, 4'b0001 << e[9:8]);
                    chk("arb_busy", arb_busy, 1);
                end
            end else begin
                chk("ready_outside_load", req_ready, 0);
            end
        end
    end

    initial begin
        #100000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n0, n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            push_byte(i, 8'($urandom), 1'b1);
            push_byte(i, 8'($urandom), 1'b1);
        end
        predict();
        repeat (4) begin
            @(negedge clk);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_arb_busy", arb_busy, 0);
        end
        reset = 1'b1;
        drain("t1_round_robin");

        @(negedge clk);
        c = cyc;
        n0 = start_cyc_q.size();
        push_byte(1, 8'h5A, 1'b1);
        predict();
        wait_starts("t2_start", n0 + 1);
        if (start_cyc_q.size() > n0) chk("t2_latency", start_cyc_q[n0], c + 2);
        drain("t2_single");

        @(negedge clk);
        push_msg(2, 20, 1'b1);
        push_byte(0, 8'($urandom), 1'b1);
        predict();
        drain("t4_burst_limit");

        @(negedge clk);
        n0 = start_cyc_q.size();
        push_msg(3, 2, 1'b0);
        push_byte(1, 8'($urandom), 1'b1);
        exp_q.push_back({2'd3, rq[3][0][7:0]});
        exp_q.push_back({2'd3, rq[3][1][7:0]});
        exp_q.push_back({2'd1, rq[1][0][7:0]});
        model_ptr = 1;
        wait_starts("t5_starts", n0 + 3);
        if (start_cyc_q.size() >= n0 + 3)
            chk_range("t5_idle_gap", start_cyc_q[n0+2] - start_cyc_q[n0+1], IDLE_TO + 2, IDLE_TO + 12);
        drain("t5_hold_timeout");

        @(negedge clk);
        chk("t6_err_before", start_to_err, 0);
        stuck = 1'b1;
        n0 = start_cyc_q.size();
        push_msg(0, 2, 1'b1);
        predict();
        wait_starts("t6_stuck_starts", n0 + 2);
        if (start_cyc_q.size() >= n0 + 2)
            chk_range("t6_start_to_gap", start_cyc_q[n0+1] - start_cyc_q[n0], START_TO + 1, START_TO + 3);
        drain("t6_stuck");
        chk("t6_err_set", start_to_err, 1);
        stuck = 1'b0;

        @(negedge clk);
        n0 = start_cyc_q.size();
        push_msg(2, 3, 1'b1);
        predict();
        wait_starts("t6_mid_start", n0 + 1);
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("t6_busy_rise");
        @(negedge clk);
        hold_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_arb_busy", arb_busy, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_err", start_to_err, 0);
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        model_ptr = N - 1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold_en = 1'b1;

        @(negedge clk);
        push_byte(3, 8'($urandom), 1'b1);
        push_byte(0, 8'($urandom), 1'b1);
        predict();
        drain("post_reset_order");

        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                n = $urandom_range(0, 2);
                for (int m = 0; m < n; m++) push_msg(i, $urandom_range(1, 20), 1'b1);
            end
            predict();
            drain("random_round");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
